// File: rtl/reverse_dabble_pkg.sv
// Shared calculator definitions: converter FSM states, BCD digit limit and
// the result-width helper used for elaboration-time sanity checks.
package reverse_dabble_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] MAX_DIGIT = 4'd9;

  // Smallest binary width able to hold 10^digits - 1.
  function automatic int min_bin_w(input int digits);
    longint unsigned max_val;
    int w;
    max_val = 1;
    for (int i = 0; i < digits; i++) begin
      max_val = max_val * 10;
    end
    max_val = max_val - 1;
    w = 0;
    while (max_val != 0) begin
      w++;
      max_val = max_val >> 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reverse_dabble_bcd_nibble_adjust.sv
// Per-digit correction for the shift-right BCD-to-binary step: a nibble that
// reached 8 or more after the shift holds a borrowed "ten" and loses 3.
module bcd_nibble_adjust (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  assign adj = (nib >= 4'd8) ? (nib - 4'd3) : nib;

endmodule

// File: rtl/reverse_dabble.sv
// Sequential packed-BCD to unsigned binary converter (reverse double dabble).
// One shift/correct iteration per clock; start/done handshake; err flags any
// captured digit above 9, in which case the result is forced to 0.
//
// state | meaning
// IDLE  | waiting for start; binary/err hold the last result
// CONV  | one shift-right + nibble correction per cycle, BIN_W iterations
// DONE  | done pulse; binary/err were loaded on entry to this state
module reverse_dabble
  import reverse_dabble_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    binary,
  output logic                err
);

  localparam int TW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < min_bin_w(DIGITS)) begin : g_bin_w_check
    $error("reverse_dabble: BIN_W cannot hold 10^DIGITS - 1");
  end

  state_t             state_q, state_d;
  logic [TW-1:0]      t_q, t_shift, t_adj;
  logic [BIN_W-1:0]   r_q, r_shift;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   binary_q;
  logic               err_q;
  logic               digit_bad;
  logic               last_iter;

  assign {t_shift, r_shift} = {t_q, r_q} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adjust u_adj (
      .nib (t_shift[4*g +: 4]),
      .adj (t_adj[4*g +: 4])
    );
  end

  // Flag any input nibble that is not a decimal digit.
  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > MAX_DIGIT) digit_bad = 1'b1;
    end
  end

  assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

  // Next-state logic; invalid digits skip straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = digit_bad ? DONE : CONV;
      CONV:    if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: capture, iterate, and load the result on the way into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      binary_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            t_q   <= bcd_in;
            r_q   <= '0;
            cnt_q <= '0;
            if (digit_bad) begin
              binary_q <= '0;
              err_q    <= 1'b1;
            end
          end
        end
        CONV: begin
          t_q   <= t_adj;
          r_q   <= r_shift;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            binary_q <= r_shift;
            err_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign binary = binary_q;
  assign err    = err_q;

endmodule

// File: tb/tb_reverse_dabble.sv
module tb_reverse_dabble;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;
  localparam int PERIOD = BIN_W + 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic [7:0]       bcd_in;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] binary;
  logic             err;

  int n_checks = 0;
  int n_errors = 0;

  reverse_dabble #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .binary (binary),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    return 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] rand_bcd();
    logic [3:0] hi, lo;
    hi = 4'($urandom_range(9, 0));
    lo = 4'($urandom_range(9, 0));
    return {hi, lo};
  endfunction

  // One full conversion from IDLE, checking latency, busy span, pulse width and result.
  task automatic run_conv(input logic [7:0] b);
    int  lat, nbusy, exp_bin, exp_err;
    bit  seen;
    exp_bin = bcd_ok(b) ? bcd_val(b) : 0;
    exp_err = bcd_ok(b) ? 0 : 1;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = 8'($urandom);
    lat = 0; nbusy = 0; seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        seen = 1'b1;
        lat  = n;
        chk("binary", int'(binary), exp_bin);
        chk("err", int'(err), exp_err);
      end
    end
    chk("done_seen", int'(seen), 1);
    chk("latency", lat, exp_err ? 0 : BIN_W);
    chk("busy_cycles", nbusy, exp_err ? 1 : BIN_W + 1);
    @(negedge clk);
    chk("done_pulse_end", int'(done), 0);
    chk("busy_after", int'(busy), 0);
    chk("binary_hold", int'(binary), exp_bin);
  endtask

  initial begin
    int         ndone;
    logic [7:0] vals [0:63];
    logic [7:0] b;

    rst = 1'b1; start = 1'b0; bcd_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_binary", int'(binary), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;

    run_conv(8'h81);

    for (int v = 0; v < 100; v++) begin
      b = {4'(v / 10), 4'(v % 10)};
      run_conv(b);
    end

    run_conv(8'h1A);
    run_conv(8'hF0);
    run_conv(8'h42);

    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom);
      run_conv(b);
    end

    // start held high, bcd_in changing every cycle
    ndone = 0;
    for (int e = 0; e < 45; e++) begin
      @(negedge clk);
      if (e > 0 && done) begin
        ndone++;
        chk("held_phase", (e - 1) % PERIOD, BIN_W);
        if ((e - 1) >= BIN_W)
          chk("held_binary", int'(binary), bcd_val(vals[e - 1 - BIN_W]));
      end
      start   = 1'b1;
      bcd_in  = rand_bcd();
      vals[e] = bcd_in;
    end
    @(negedge clk);
    start = 1'b0;
    chk("held_done_count", ndone, 5);
    repeat (12) @(negedge clk);
    chk("held_idle", int'(busy), 0);

    run_conv(8'h93);

    // reset during iteration 4 of 57
    @(negedge clk);
    start = 1'b1; bcd_in = 8'h57;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_binary", int'(binary), 0);
    chk("midrst_err", int'(err), 0);
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_binary_hold", int'(binary), 0);
    run_conv(8'h57);

    // rst and start together
    @(negedge clk);
    rst = 1'b1; start = 1'b1; bcd_in = 8'h33;
    @(negedge clk);
    chk("rststart_busy", int'(busy), 0);
    chk("rststart_binary", int'(binary), 0);
    chk("rststart_err", int'(err), 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rststart_busy2", int'(busy), 0);
    chk("rststart_done", int'(done), 0);
    chk("rststart_binary2", int'(binary), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
